// File: rtl/uart_pkg.sv
// uart_pkg: shared parity/FSM types and parity-name decoding for the UART datapath
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} par_t;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic par_t par_of(input logic [31:0] pt);
        return pt == "EVEN" ? PAR_EVEN : pt == "ODD" ? PAR_ODD : PAR_NONE;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for the serial line, resets to the idle (high) level
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    // shift the pin through two flops
    always_ff @(posedge clk) ff <= rst ? 2'b11 : {ff[0], d};

    assign q = ff[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with valid/ready output; UART_RX_SYNC_EN adds a 2-flop input synchronizer
module uart_rx import uart_pkg::*; #(
    parameter int DW = 8,
    parameter     PT = "NONE",
    parameter int SW = 1,
    parameter int BN = 54
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uart_rxd,
    output logic          str_rxd_tvalid,
    output logic [DW-1:0] str_rxd_tdata,
    input  logic          str_rxd_tready,
    output logic          error_fifo,
    output logic          error_parity,
    output logic          error_frame
);

    localparam par_t PAR = par_of(PT);
    localparam int PB = PAR == PAR_NONE ? 0 : 1;
    localparam int CW = $clog2(BN);
    localparam int BW = $clog2(DW + 3);
    localparam logic [CW-1:0] HALF = CW'(BN / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BN - 1);
    localparam logic [BW-1:0] DLAST = BW'(DW - 1);
    localparam logic [BW-1:0] LAST = BW'(DW + PB + SW - 1);

    logic          rxd;
    state_t        state, state_nx;
    logic [CW-1:0] baud_cnt;
    logic [BW-1:0] bit_cnt;
    logic [DW-1:0] shreg;
    logic          par_bit, frm_lat;
    logic          tick, smp, last, par_err, full;

`ifdef UART_RX_SYNC_EN
    uart_sync u_sync (.clk(clk), .rst(rst), .d(uart_rxd), .q(rxd));
`else
    assign rxd = uart_rxd;
`endif

    // state register
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    // frame sequencing: false starts fall back to IDLE, parity state only when enabled
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = rxd ? IDLE : START;
            START:   if (tick) state_nx = rxd ? IDLE : DATA;
            DATA:    if (tick && bit_cnt == DLAST) state_nx = PB != 0 ? PARITY : STOP;
            PARITY:  if (tick) state_nx = STOP;
            STOP:    if (last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // sample strobes derived from the state and the baud counter
    always_comb begin
        tick = baud_cnt == '0;
        smp  = tick && (state == DATA || state == PARITY || state == STOP);
        last = tick && state == STOP && bit_cnt == LAST;
    end

    assign par_err = PAR == PAR_EVEN ? ^{shreg, par_bit} : PAR == PAR_ODD ? ~^{shreg, par_bit} : 1'b0;
    assign full    = str_rxd_tvalid & ~str_rxd_tready;

    // baud/bit counters, data shift register, parity bit and stop-bit error latch
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            frm_lat  <= 1'b0;
        end else begin
            baud_cnt <= state == IDLE ? (rxd ? '0 : HALF) : tick ? FULL : baud_cnt - 1'b1;
            bit_cnt  <= state == IDLE ? '0 : (smp && !last) ? bit_cnt + 1'b1 : bit_cnt;
            frm_lat  <= state == IDLE ? 1'b0 : frm_lat | (smp && state == STOP && !rxd);
            if (smp && state == DATA) shreg <= {rxd, shreg[DW-1:1]};
            if (smp && state == PARITY) par_bit <= rxd;
        end
    end

    // holding register and status pulses, issued the cycle after the last stop sample
    always_ff @(posedge clk) begin
        if (rst) begin
            str_rxd_tvalid <= 1'b0;
            str_rxd_tdata  <= '0;
            error_fifo     <= 1'b0;
            error_parity   <= 1'b0;
            error_frame    <= 1'b0;
        end else begin
            error_fifo   <= last & full;
            error_parity <= last & par_err;
            error_frame  <= last & (frm_lat | ~rxd);
            if (last && !full) begin
                str_rxd_tvalid <= 1'b1;
                str_rxd_tdata  <= shreg;
            end else if (str_rxd_tready) begin
                str_rxd_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: two receivers (no parity / even parity) fed random and directed frames, checked by a scoreboard
module tb_uart_rx;

    localparam int DW = 8;
    localparam int SW = 1;
    localparam int BN = 54;
    localparam int LIMIT = 90000;
`ifdef UART_RX_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] rxd = 2'b11;
    logic [1:0] tready = 2'b11;
    logic       tvalid [2];
    logic       ef [2];
    logic       ep [2];
    logic       efr [2];
    logic [7:0] tdata [2];

    item_t      q0[$];
    item_t      q1[$];
    logic [1:0] hv = 2'b00;
    logic [1:0] known = 2'b11;
    logic [7:0] hd [2] = '{8'h00, 8'h00};
    logic [2:0] pend [2] = '{3'b000, 3'b000};
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         done = 1'b0;
    bit         stop = 1'b0;

    uart_rx #(.DW(DW), .PT("NONE"), .SW(SW), .BN(BN)) u_none (
        .clk(clk), .rst(rst), .uart_rxd(rxd[0]),
        .str_rxd_tvalid(tvalid[0]), .str_rxd_tdata(tdata[0]), .str_rxd_tready(tready[0]),
        .error_fifo(ef[0]), .error_parity(ep[0]), .error_frame(efr[0])
    );

    uart_rx #(.DW(DW), .PT("EVEN"), .SW(SW), .BN(BN)) u_even (
        .clk(clk), .rst(rst), .uart_rxd(rxd[1]),
        .str_rxd_tvalid(tvalid[1]), .str_rxd_tdata(tdata[1]), .str_rxd_tready(tready[1]),
        .error_fifo(ef[1]), .error_parity(ep[1]), .error_frame(efr[1])
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        if (n > 0) #1;
    endtask

    // drive one frame on lane l and record when and what the receiver must deliver
    task automatic send(input int l, input logic [7:0] d, input bit bad_par, input bit bad_stop);
        item_t it;
        int    npar;
        npar    = l == 1 ? 1 : 0;
        it.cyc  = cyc + BN / 2 + (DW + npar + SW) * BN + 1 + SL;
        it.data = d;
        it.perr = l == 1 && bad_par;
        it.ferr = bad_stop;
        if (l == 0) q0.push_back(it);
        else q1.push_back(it);
        rxd[l] = 1'b0;
        step(BN);
        for (int k = 0; k < DW; k++) begin
            rxd[l] = d[k];
            step(BN);
        end
        if (l == 1) begin
            rxd[l] = ^d ^ bad_par;
            step(BN);
        end
        if (bad_stop) begin
            rxd[l] = 1'b0;
            step(BN / 2 + 1);
            rxd[l] = 1'b1;
            step(BN - BN / 2 - 1);
        end else begin
            rxd[l] = 1'b1;
            step(BN);
        end
    endtask

    // compare lane l against the holding-register model, then advance the model one cycle
    task automatic mon(input int l);
        logic [3:0] act, exp;
        item_t      it;
        bit         has;
        act = {tvalid[l], ef[l], ep[l], efr[l]};
        exp = {hv[l], pend[l]};
        if (act != 4'b0 || exp != 4'b0 || known[l]) begin
            checks++;
            if (act != exp || ((hv[l] || known[l]) && tdata[l] != hd[l])) begin
                failures++;
                $display("FAIL lane%0d cyc=%0d tvalid/fifo/par/frame got=%b tdata=%h want=%b tdata=%h",
                         l, cyc, act, tdata[l], exp, hd[l]);
            end
        end
        pend[l] = 3'b000;
        has = l == 0 ? q0.size() != 0 : q1.size() != 0;
        if (has) it = l == 0 ? q0[0] : q1[0];
        if (rst) begin
            hv[l]    = 1'b0;
            hd[l]    = 8'h00;
            known[l] = 1'b1;
        end else if (has && it.cyc == cyc + 1) begin
            if (l == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
            pend[l] = {hv[l] & ~tready[l], it.perr, it.ferr};
            if (!pend[l][2]) begin
                hv[l]    = 1'b1;
                hd[l]    = it.data;
                known[l] = 1'b0;
            end
        end else if (hv[l] && tready[l]) begin
            hv[l] = 1'b0;
        end
    endtask

    initial forever begin
        @(negedge clk);
        mon(0);
        mon(1);
        if (done || cyc > LIMIT) begin
            if (!done) begin
                failures++;
                $display("FAIL timeout cyc=%0d pending=%0d/%0d want 0/0", cyc, q0.size(), q1.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        @(posedge clk);
        #1;
        step(3);
        rst = 1'b0;
        step(5);
        send(0, 8'hA5, 1'b0, 1'b0);
        step(20);
        send(1, 8'h03, 1'b1, 1'b0);
        send(1, 8'h03, 1'b0, 1'b0);
        step(20);
        send(0, 8'h5A, 1'b0, 1'b1);
        send(0, 8'h3C, 1'b0, 1'b0);
        step(20);
        tready[0] = 1'b0;
        send(0, 8'h11, 1'b0, 1'b0);
        send(0, 8'h22, 1'b0, 1'b0);
        step(30);
        tready[0] = 1'b1;
        step(5);
        rxd[0] = 1'b0;
        step(10);
        rxd[0] = 1'b1;
        step(18);
        send(0, 8'hC3, 1'b0, 1'b0);
        step(20);
        rxd[1] = 1'b0;
        step(3 * BN);
        rst = 1'b1;
        rxd[1] = 1'b1;
        step(2);
        rst = 1'b0;
        step(BN);
        send(1, 8'h96, 1'b0, 1'b0);
        step(20);
        fork
            begin
                fork
                    for (int n = 0; n < 12; n++) begin
                        step($urandom_range(0, 1) != 0 ? 0 : $urandom_range(1, BN));
                        send(0, 8'($urandom), 1'b0, $urandom_range(0, 7) == 0);
                    end
                    for (int n = 0; n < 12; n++) begin
                        step($urandom_range(0, 1) != 0 ? 0 : $urandom_range(1, BN));
                        send(1, 8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
                    end
                join
                stop = 1'b1;
            end
            while (!stop) begin
                tready = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0};
                step(1);
            end
        join
        tready = 2'b11;
        while (q0.size() != 0 || q1.size() != 0) step(1);
        step(10);
        done = 1'b1;
    end

endmodule
